// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU entry sequencer.
`timescale 1ns/1ps

package alu_seq_pkg;

  // Entry steps, in the order the user walks through them
  typedef enum logic [1:0] {S_A, S_B, S_OP, S_RES} entry_state_t;

  localparam int DB_CYCLES_DEFAULT = 10;

  // One-hot step indicator: bit 0 = operand A ... bit 3 = result
  function automatic logic [3:0] state_onehot(input entry_state_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button front end: 2-flop synchronizer, optional debounce counter,
// and a single-cycle press pulse on the rising edge of the clean level.
// The debounce counter is compiled in only when ALU_SEQ_DEBOUNCE_EN is defined;
// otherwise the synchronizer output is used as the clean level directly.
`timescale 1ns/1ps

module button_debouncer
  import alu_seq_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  // The counter is 8 bits wide, so the stability window must fit in it
  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
    $error("button_debouncer: DB_CYCLES must be in 1..255");
  end

  logic sync1_q;
  logic sync2_q;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  logic       level_q;
  logic       level_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Count consecutive samples that disagree with the clean level; the press
  // fires combinationally on the same edge that flips the level high so the
  // downstream strobe register catches it without an extra cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = 8'd0;
    press   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == 8'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        press   = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Hold the debounced level and the stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  logic level_prev_q;

  // Remember last cycle's synchronized level to find its rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign press = sync2_q & ~level_prev_q;
`endif

endmodule

// File: rtl/alu_entry_sequencer.sv
// Steps the user through operand A, operand B, opcode and result publish with
// one push-button, emitting one registered single-cycle load strobe per press.
// btn_clear aborts entry back to operand A. Debounce of btn_next is enabled by
// defining ALU_SEQ_DEBOUNCE_EN (see button_debouncer).
`timescale 1ns/1ps

module alu_entry_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_clear,
  output logic       load_a,
  output logic       load_b,
  output logic       load_op,
  output logic       update_res,
  output logic [3:0] step_led
);

  logic next_press;
  logic next_level_unused;

  button_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_next_btn (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_next),
    .level  (next_level_unused),
    .press  (next_press)
  );

  logic clr_sync1_q;
  logic clr_sync2_q;

  // Clear is level-sensitive, so it only needs synchronizing, not debouncing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_sync1_q <= 1'b0;
      clr_sync2_q <= 1'b0;
    end else begin
      clr_sync1_q <= btn_clear;
      clr_sync2_q <= clr_sync1_q;
    end
  end

  entry_state_t state_q;
  entry_state_t state_d;
  logic [3:0]   strobe_q;
  logic [3:0]   strobe_d;

  // Next step and strobe; clear overrides a simultaneous press and discards it
  always_comb begin
    state_d  = state_q;
    strobe_d = 4'b0000;
    if (clr_sync2_q) begin
      state_d = S_A;
    end else if (next_press) begin
      strobe_d = state_onehot(state_q);
      case (state_q)
        S_A:     state_d = S_B;
        S_B:     state_d = S_OP;
        S_OP:    state_d = S_RES;
        S_RES:   state_d = S_A;
        default: state_d = S_A;
      endcase
    end
  end

  // State and strobe registers advance together so step_led moves with the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_A;
      strobe_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
    end
  end

  assign load_a     = strobe_q[0];
  assign load_b     = strobe_q[1];
  assign load_op    = strobe_q[2];
  assign update_res = strobe_q[3];
  assign step_led   = state_onehot(state_q);

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed bench for alu_entry_sequencer with hand-computed expectations for
// both the debounced (ALU_SEQ_DEBOUNCE_EN) and fast builds.
`timescale 1ns/1ps

module tb_alu_entry_sequencer;

  localparam int DB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  // Edges after the first sampling edge at which the strobe appears
  localparam int LAT = DEB ? DB + 1 : 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnNext;
  logic       btnClear;
  logic       loadA;
  logic       loadB;
  logic       loadOp;
  logic       updateRes;
  logic [3:0] stepLed;
  logic [3:0] strobeVec;

  int vectorCount = 0;
  int missCount   = 0;
  int multiHot    = 0;

  int         edgeIdx;
  int         firstEdge;
  int         seenStrobes;
  logic [3:0] seenVec;

  logic [3:0] expStrobe [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] expStep   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  alu_entry_sequencer #(
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btnNext),
    .btn_clear (btnClear),
    .load_a    (loadA),
    .load_b    (loadB),
    .load_op   (loadOp),
    .update_res(updateRes),
    .step_led  (stepLed)
  );

  assign strobeVec = {updateRes, loadOp, loadB, loadA};

  // 10 ns clock; outputs are sampled on the falling edge
  always #5 clk = ~clk;

  // Watch for any cycle with more than one strobe high
  always @(negedge clk) begin
    if ($countones(strobeVec) > 1) multiHot++;
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Forget strobes seen so far and restart the edge counter
  task automatic clearTally();
    edgeIdx     = -1;
    firstEdge   = -1;
    seenStrobes = 0;
    seenVec     = 4'b0000;
  endtask

  // Hold the buttons for a number of cycles, tallying strobes at each negedge
  task automatic applyStimulus(input logic nxt, input logic clr, input int cycles);
    btnNext  = nxt;
    btnClear = clr;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      edgeIdx++;
      seenStrobes += $countones(strobeVec);
      seenVec     |= strobeVec;
      if (strobeVec != 4'b0000 && firstEdge < 0) firstEdge = edgeIdx;
    end
  endtask

  // Reset for two cycles and return on a falling edge with buttons idle
  task automatic doReset();
    btnNext  = 1'b0;
    btnClear = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full press-and-release helper
  task automatic pressOnce();
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  initial begin
    btnNext  = 1'b0;
    btnClear = 1'b0;
    reset    = 1'b1;
    #1;
    checkOutput("reset strobes", 32'(strobeVec), 32'h0);
    checkOutput("reset step", 32'(stepLed), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    clearTally();
    applyStimulus(1'b0, 1'b0, 50);
    checkOutput("idle strobes", 32'(seenStrobes), 32'd0);
    checkOutput("idle step", 32'(stepLed), 32'h1);

    // Four clean presses walk through every step
    for (int i = 0; i < 4; i++) begin
      clearTally();
      pressOnce();
      checkOutput("press latency", 32'(firstEdge), 32'(LAT));
      checkOutput("press strobe", 32'(seenVec), 32'(expStrobe[i]));
      checkOutput("press count", 32'(seenStrobes), 32'd1);
      checkOutput("press step", 32'(stepLed), 32'(expStep[i]));
    end

    // 3-cycle glitch then 4-cycle pulse
    doReset();
    clearTally();
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("glitch3 count", 32'(seenStrobes), DEB ? 32'd0 : 32'd1);
    checkOutput("glitch3 step", 32'(stepLed), DEB ? 32'h1 : 32'h2);
    clearTally();
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("pulse4 count", 32'(seenStrobes), 32'd1);
    checkOutput("pulse4 strobe", 32'(seenVec), DEB ? 32'h1 : 32'h2);
    checkOutput("pulse4 step", 32'(stepLed), DEB ? 32'h2 : 32'h4);

    // Long hold then bouncing release
    doReset();
    clearTally();
    applyStimulus(1'b1, 1'b0, 100);
    checkOutput("hold count", 32'(seenStrobes), 32'd1);
    checkOutput("hold strobe", 32'(seenVec), 32'h1);
    clearTally();
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b1, 1'b0, 2);
    end
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("bounce count", 32'(seenStrobes), DEB ? 32'd0 : 32'd3);
    checkOutput("bounce step", 32'(stepLed), DEB ? 32'h2 : 32'h1);

    // Clear lands on the edge that would have issued load_op
    doReset();
    pressOnce();
    pressOnce();
    checkOutput("in S_OP", 32'(stepLed), 32'h4);
    clearTally();
    for (int e = 0; e < 20; e++) begin
      applyStimulus(e < 10, (e >= LAT - 2) && (e <= LAT), 1);
      if (e == LAT) checkOutput("clear step", 32'(stepLed), 32'h1);
    end
    checkOutput("clear strobes", 32'(seenStrobes), 32'd0);
    clearTally();
    pressOnce();
    checkOutput("post-clear strobe", 32'(seenVec), 32'h1);
    checkOutput("post-clear step", 32'(stepLed), 32'h2);

    // Reset while load_b is high, button still held afterwards
    doReset();
    pressOnce();
    clearTally();
    applyStimulus(1'b1, 1'b0, LAT + 1);
    checkOutput("pre-reset load_b", 32'(strobeVec), 32'h2);
    reset = 1'b1;
    #1;
    checkOutput("async strobe drop", 32'(strobeVec), 32'h0);
    checkOutput("async step", 32'(stepLed), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    clearTally();
    pressOnce();
    checkOutput("held-after-reset latency", 32'(firstEdge), 32'(LAT));
    checkOutput("held-after-reset strobe", 32'(seenVec), 32'h1);
    checkOutput("held-after-reset count", 32'(seenStrobes), 32'd1);

    checkOutput("one-hot strobes", 32'(multiHot), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
